// File: rtl/ram_reader.sv
// Burst reader: walks an SRAM address range through a single-outstanding read port
// and streams the returned bytes out of a 4-entry first-word-fall-through FIFO.
module ram_reader (
  input  logic        i_clk,
  input  logic        i_nreset,
  input  logic        i_start,
  input  logic [14:0] i_base_addr,
  input  logic [14:0] i_length,
  output logic [14:0] o_rd_addr,
  output logic        o_rd_req,
  input  logic        i_rd_ack,
  input  logic [7:0]  i_ram_data,
  output logic [7:0]  o_dout,
  output logic        o_dout_valid,
  input  logic        i_dout_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a byte moves to the consumer on every edge where o_dout_valid and
  // i_dout_ready are both high; a read completes on the edge ending an i_rd_ack
  // cycle, and only counts while o_rd_req (the outstanding flag) is high.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_rd_req, w_rd_req_nxt;
  logic        r_done, w_done_nxt;
  logic [14:0] r_addr, r_remaining;
  logic [7:0]  r_mem [4];
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count, w_count_nxt;
  logic        w_push, w_pop, w_capture;

  assign w_pop       = (r_count != 3'd0) && i_dout_ready;
  assign w_push      = (r_state == S_REQ) && r_rd_req && i_rd_ack;
  assign w_capture   = (r_state == S_IDLE) && i_start && (i_length != 15'd0);
  assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_req_nxt = r_rd_req;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_length == 15'd0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt  = S_REQ;
            w_rd_req_nxt = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (w_push) begin
          // Last byte of the burst takes priority over a full FIFO.
          if (r_remaining == 15'd1) begin
            w_state_nxt  = S_DRAIN;
            w_rd_req_nxt = 1'b0;
          end else if (w_count_nxt == 3'd4) begin
            w_state_nxt  = S_HOLD;
            w_rd_req_nxt = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (w_pop) begin
          w_state_nxt  = S_REQ;
          w_rd_req_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_pop && (r_count == 3'd1)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_rd_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_state     <= S_IDLE;
      r_rd_req    <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= 15'd0;
      r_remaining <= 15'd0;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_count     <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_req <= w_rd_req_nxt;
      r_done   <= w_done_nxt;
      r_count  <= w_count_nxt;
      if (w_capture) begin
        r_addr      <= i_base_addr;
        r_remaining <= i_length;
      end else if (w_push) begin
        r_addr      <= r_addr + 15'd1;
        r_remaining <= r_remaining - 15'd1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (i_nreset && w_push) r_mem[r_wr_ptr] <= i_ram_data;
  end

  assign o_rd_addr    = r_addr;
  assign o_rd_req     = r_rd_req;
  assign o_dout       = r_mem[r_rd_ptr];
  assign o_dout_valid = (r_count != 3'd0);
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader: a 3-cycle SRAM controller model, an address/byte
// expectation queue per burst, and a per-cycle compare process.
module tb_ram_reader;

  logic        clk = 1'b0;
  logic        nreset, start, rd_ack, dout_ready;
  logic [14:0] base_addr, length, rd_addr;
  logic        rd_req, dout_valid, busy, done;
  logic [7:0]  ram_data, dout;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  ram_reader dut (
    .i_clk(clk), .i_nreset(nreset), .i_start(start), .i_base_addr(base_addr),
    .i_length(length), .o_rd_addr(rd_addr), .o_rd_req(rd_req), .i_rd_ack(rd_ack),
    .i_ram_data(ram_data), .o_dout(dout), .o_dout_valid(dout_valid),
    .i_dout_ready(dout_ready), .o_busy(busy), .o_done(done), .o_dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [14:0] exp_addr_q[$];
  int ack_cnt = 0;
  int raw_ack_cnt = 0;
  int done_cnt = 0;
  int occ = 0;
  logic busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ram_byte(input logic [14:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Controller model: latches a read when rd_req is seen, acks in its third cycle,
  // and finishes a latched read even if rd_req is withdrawn meanwhile.
  initial begin
    logic        pend;
    logic [14:0] pend_addr;
    int          cnt;
    pend = 1'b0; pend_addr = '0; cnt = 0;
    rd_ack = 1'b0; ram_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rd_ack) begin
        rd_ack = 1'b0;
        if (rd_req) begin pend = 1'b1; pend_addr = rd_addr; cnt = 1; end
      end else if (pend) begin
        cnt++;
        if (cnt == 3) begin
          rd_ack = 1'b1; ram_data = ram_byte(pend_addr); pend = 1'b0; raw_ack_cnt++;
        end
      end else if (rd_req) begin
        pend = 1'b1; pend_addr = rd_addr; cnt = 1;
      end
    end
  end

  // Compare process: FIFO occupancy model, byte order, address order, stability.
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [14:0] prev_addr = '0;
  always @(negedge clk) begin
    check("dout_valid", dout_valid, occ != 0);
    if (busy) busy_seen = 1'b1;
    if (done) done_cnt++;
    if (nreset && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dout: got 0x%0h, expected no byte", dout);
      end else check("dout", dout, exp_q.pop_front());
    end
    if (nreset && rd_ack && rd_req) begin
      ack_cnt++;
      check("no_overflow", occ < 4, 1);
      if (exp_addr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_addr: got 0x%0h, expected no read", rd_addr);
      end else check("rd_addr", rd_addr, exp_addr_q.pop_front());
    end
    if (prev_req && rd_req && !prev_ack) check("rd_addr_stable", rd_addr, prev_addr);
    if (!nreset) occ = 0;
    else occ = occ + int'(rd_ack && rd_req) - int'(dout_valid && dout_ready);
    prev_req = rd_req; prev_ack = rd_ack; prev_addr = rd_addr;
  end

  task automatic model_burst(input logic [14:0] base, input int len);
    logic [14:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + 15'(i);
      exp_addr_q.push_back(a);
      exp_q.push_back(ram_byte(a));
    end
  endtask

  task automatic pulse_start(input logic [14:0] base, input logic [14:0] len);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; length = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_burst(input int d0, input string name);
    int i;
    i = 0;
    while (done_cnt == d0 && i < 400) begin @(posedge clk); i++; end
    check({name, "_done_seen"}, done_cnt != d0, 1);
    repeat (3) @(negedge clk);
    check({name, "_busy_low"}, busy, 1'b0);
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_bytes_left"}, exp_q.size(), 0);
    check({name, "_addrs_left"}, exp_addr_q.size(), 0);
  endtask

  initial begin
    int d0, a0, i;
    logic [7:0] pat;
    nreset = 1'b0; start = 1'b0; base_addr = '0; length = '0; dout_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    nreset = 1'b1;
    @(negedge clk);
    check("rst_rd_addr", rd_addr, 15'h0000);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Plain 3-byte burst, literal expectations.
    exp_addr_q = '{15'h1000, 15'h1001, 15'h1002};
    exp_q = '{8'h5A, 8'h5B, 8'h58};
    d0 = done_cnt;
    pulse_start(15'h1000, 15'd3);
    @(negedge clk);
    check("b3_busy_high", busy, 1'b1);
    check("b3_rd_req_high", rd_req, 1'b1);
    finish_burst(d0, "b3");

    // Consumer stalled: four reads fill the FIFO, then the reader holds.
    dout_ready = 1'b0;
    model_burst(15'h0400, 6);
    d0 = done_cnt; a0 = ack_cnt;
    pulse_start(15'h0400, 15'd6);
    i = 0;
    while (ack_cnt - a0 < 4 && i < 200) begin @(negedge clk); i++; end
    repeat (6) @(negedge clk);
    check("hold_reads", ack_cnt - a0, 4);
    check("hold_rd_req_low", rd_req, 1'b0);
    check("hold_busy", busy, 1'b1);
    check("hold_dout", dout, 8'h5A);
    @(posedge clk); #1;
    dout_ready = 1'b1;
    finish_burst(d0, "hold");
    check("hold_total_reads", ack_cnt - a0, 6);

    // Address wrap at the top of the space, literal expectations.
    exp_addr_q = '{15'h7FFE, 15'h7FFF, 15'h0000};
    exp_q = '{8'hA4, 8'hA5, 8'h5A};
    d0 = done_cnt;
    pulse_start(15'h7FFE, 15'd3);
    finish_burst(d0, "wrap");

    // Empty burst.
    busy_seen = 1'b0; d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 15'h0222; length = 15'd0;
    @(negedge clk);
    check("len0_done_early", done, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("len0_done", done, 1'b1);
    check("len0_rd_req", rd_req, 1'b0);
    @(negedge clk);
    check("len0_done_one_cycle", done, 1'b0);
    repeat (4) @(negedge clk);
    check("len0_busy_never", busy_seen, 1'b0);
    check("len0_done_pulses", done_cnt - d0, 1);

    // Start pulsed mid-burst is ignored.
    model_burst(15'h0300, 5);
    d0 = done_cnt;
    pulse_start(15'h0300, 15'd5);
    repeat (4) @(posedge clk);
    pulse_start(15'h0555, 15'd2);
    finish_burst(d0, "midstart");

    // Patterned consumer throttling over a longer burst.
    model_burst(15'h0123, 9);
    d0 = done_cnt; pat = 8'b1011_0010;
    pulse_start(15'h0123, 15'd9);
    i = 0;
    while (done_cnt == d0 && i < 400) begin
      @(posedge clk); #1;
      dout_ready = pat[i % 8];
      i++;
    end
    dout_ready = 1'b1;
    finish_burst(d0, "throttle");

    // Reset while a read is outstanding; the late ack must be dropped.
    a0 = raw_ack_cnt; d0 = done_cnt;
    pulse_start(15'h2000, 15'd2);
    i = 0;
    while (!rd_req && i < 20) begin @(negedge clk); i++; end
    check("rst_mid_req_seen", rd_req, 1'b1);
    @(posedge clk); #1;
    nreset = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rst_mid_rd_req", rd_req, 1'b0);
      check("rst_mid_dout_valid", dout_valid, 1'b0);
    end
    check("rst_mid_late_ack", raw_ack_cnt - a0, 1);
    check("rst_mid_rd_addr", rd_addr, 15'h0000);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_no_done", done_cnt - d0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_reader.md
RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 clk  input  1  sole clock; all state changes on its rising edge.
REQ-002 nreset  input  1  reset; synchronous, active-low.
REQ-003 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-004 base_addr  input  15  first SRAM address of the burst; captured with start.
REQ-005 length  input  15  number of bytes to read; captured with start; 0 means empty burst.
REQ-006 rd_addr  output  15  read address presented to the SRAM controller read port.
REQ-007 rd_req  output  1  read request to the controller; registered.
REQ-008 rd_ack  input  1  controller read acknowledge; one-cycle pulse, data valid in that cycle.
REQ-009 ram_data  input  8  SRAM data bus; sampled on the clk edge that ends an rd_ack cycle.
REQ-010 dout  output  8  head of internal FIFO.
REQ-011 dout_valid  output  1  dout holds a valid byte.
REQ-012 dout_ready  input  1  consumer accepts dout when dout_valid and dout_ready are both high.
REQ-013 busy  output  1  burst in progress, including FIFO drain.
REQ-014 done  output  1  one-cycle pulse when a burst completes.

Function
REQ-015 States SHALL be IDLE, REQ (rd_req high, read outstanding), HOLD (FIFO has no free slot, no request), DRAIN (all bytes read, FIFO not yet empty).
REQ-016 IDLE + start, length!=0: capture base_addr into addr counter and length into remaining, go to REQ, rd_req=1 from next cycle.
REQ-017 IDLE + start, length=0: no read issued; done pulses on the next cycle; stay IDLE.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 rd_addr SHALL equal the addr counter and stay stable from rd_req rising until the rd_ack cycle inclusive.
REQ-020 At most one read outstanding; rd_req SHALL stay high until the rd_ack cycle.
REQ-021 On the rd_ack edge: push ram_data into FIFO, addr counter +1 (wraps 0x7FFF->0x0000), remaining -1.
REQ-022 Next state after rd_ack: remaining=0 -> DRAIN; FIFO occupancy after push and same-cycle pop =4 -> HOLD; else REQ with rd_req kept high (back-to-back read).
REQ-023 HOLD -> REQ on the edge where a pop makes a slot free; rd_req rises the following cycle.
REQ-024 FIFO SHALL be 4 entries deep, first-word-fall-through; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-025 FIFO SHALL never overflow; a push into a full FIFO is a design error.
REQ-026 DRAIN -> IDLE on the edge where the last byte pops; done pulses in the cycle after that edge; busy drops the same cycle.
REQ-027 busy SHALL be high in REQ, HOLD and DRAIN, low in IDLE.
REQ-028 rd_ack while no read is outstanding (e.g. after reset mid-read) SHALL be ignored; no push.
REQ-029 dout_valid SHALL equal FIFO non-empty; dout undefined-but-stable when invalid.

Reset
REQ-030 nreset low at a clk edge SHALL force IDLE, rd_req=0, dout_valid=0, busy=0, done=0, FIFO empty, outstanding flag cleared, addr counter=0, remaining=0.
REQ-031 Reset SHALL take priority over start, rd_ack and dout_ready in the same cycle.
REQ-032 rd_addr SHALL read 0 after reset.

Verification
REQ-033 start, base_addr=0x1000, length=3, dout_ready=1, controller model 3-cycle reads -> rd_addr 0x1000,0x1001,0x1002; dout returns model bytes in order; one done pulse; busy low after.
REQ-034 length=6, dout_ready=0 -> exactly 4 reads then rd_req low (HOLD); raise dout_ready -> remaining 2 reads issue; 6 bytes in order.
REQ-035 base_addr=0x7FFE, length=3 -> rd_addr 0x7FFE,0x7FFF,0x0000.
REQ-036 start with length=0 -> no rd_req, done one cycle later, busy never high.
REQ-037 nreset low while rd_req high, then model delivers rd_ack -> no push, dout_valid stays 0, rd_req stays 0.
REQ-038 start pulsed mid-burst with different base_addr -> ignored; original address sequence unchanged.
